// File: rtl/rs232_pkg.sv
// Shared constants, request codes and state encodings for the USB-to-RS-232 transmit path.
package rs232_pkg;

    localparam logic [15:0] DIV_DEFAULT = 16'd1085;
    localparam logic [15:0] DIV_MIN     = 16'd4;
    localparam int          BUF_RD_LAT  = 2;
    localparam logic [9:0]  MAX_LEN     = 10'd512;

    localparam logic [7:0] REQ_SET_DIV = 8'h02;
    localparam logic [7:0] REQ_SET_FC  = 8'h03;

    typedef enum logic [3:0] {
        ST_RST,
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_CTS,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_ARM
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_START,
        PH_DATA,
        PH_STOP
    } phase_t;

    function automatic logic [15:0] clamp_div(input logic [15:0] val);
        return (val < DIV_MIN) ? DIV_MIN : val;
    endfunction

endpackage

// File: rtl/uart_tx_ser.sv
// 8N1 serialiser: byte and divider are captured on load, the frame runs from start.
module uart_tx_ser
    import rs232_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [7:0]  tx_byte,
    input  logic [15:0] bit_div,
    input  logic        start,
    output logic        bit_end,
    output logic        last_bit,
    output logic        done,
    output logic        txd
);

    phase_t      phase_reg;
    logic [15:0] timer_reg;
    logic [15:0] frame_div_reg;
    logic [7:0]  shreg_reg;
    logic [2:0]  bit_cnt_reg;

    assign bit_end  = (phase_reg != PH_IDLE) && (timer_reg == 16'd0);
    assign last_bit = (bit_cnt_reg == 3'd7);
    assign done     = bit_end && (phase_reg == PH_STOP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_reg     <= PH_IDLE;
            timer_reg     <= 16'd0;
            frame_div_reg <= DIV_DEFAULT;
            shreg_reg     <= 8'd0;
            bit_cnt_reg   <= 3'd0;
            txd           <= 1'b1;
        end else begin
            // load and start never coincide: the parent visits a CTS state in between
            if (load) begin
                shreg_reg     <= tx_byte;
                frame_div_reg <= bit_div;
            end
            case (phase_reg)
                PH_IDLE: begin
                    txd <= 1'b1;
                    if (start) begin
                        phase_reg <= PH_START;
                        txd       <= 1'b0;
                        timer_reg <= frame_div_reg - 16'd1;
                    end
                end
                PH_START: begin
                    if (timer_reg == 16'd0) begin
                        phase_reg   <= PH_DATA;
                        txd         <= shreg_reg[0];
                        shreg_reg   <= {1'b0, shreg_reg[7:1]};
                        bit_cnt_reg <= 3'd0;
                        timer_reg   <= frame_div_reg - 16'd1;
                    end else begin
                        timer_reg <= timer_reg - 16'd1;
                    end
                end
                PH_DATA: begin
                    if (timer_reg == 16'd0) begin
                        timer_reg <= frame_div_reg - 16'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            phase_reg <= PH_STOP;
                            txd       <= 1'b1;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            txd         <= shreg_reg[0];
                            shreg_reg   <= {1'b0, shreg_reg[7:1]};
                        end
                    end else begin
                        timer_reg <= timer_reg - 16'd1;
                    end
                end
                PH_STOP: begin
                    if (timer_reg == 16'd0) begin
                        phase_reg <= PH_IDLE;
                    end else begin
                        timer_reg <= timer_reg - 16'd1;
                    end
                end
                default: phase_reg <= PH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/rs232_usb_tx.sv
// Drains a USB OUT endpoint buffer onto TXD as 8N1 frames, with optional CTS gating
// and vendor-request control of divider and flow control.
module rs232_usb_tx
    import rs232_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    output logic [8:0]  buf_out_addr,
    input  logic [7:0]  buf_out_q,
    input  logic [9:0]  buf_out_len,
    input  logic        buf_out_hasdata,
    output logic        buf_out_arm,
    input  logic        buf_out_arm_ack,
    input  logic        vend_req_act,
    input  logic [7:0]  vend_req_request,
    input  logic [15:0] vend_req_val,
    output logic        rs232_txd,
    input  logic        rs232_cts,
    output logic        tx_busy
);

    logic       rst_meta_reg;
    logic       rst_n_reg;
    logic [3:0] async_in;
    logic [3:0] sync_meta_reg;
    logic [3:0] sync_reg;

    always_ff @(posedge clk) begin
        rst_meta_reg <= reset_n;
        rst_n_reg    <= rst_meta_reg;
    end

    assign async_in = {vend_req_act, rs232_cts, buf_out_arm_ack, buf_out_hasdata};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                sync_meta_reg[gi] <= async_in[gi];
                sync_reg[gi]      <= sync_meta_reg[gi];
            end
        end
    endgenerate

    logic hasdata_s;
    logic arm_ack_s;
    logic cts_s;
    logic vend_s;

    assign hasdata_s = sync_reg[0];
    assign arm_ack_s = sync_reg[1];
    assign cts_s     = sync_reg[2];
    assign vend_s    = sync_reg[3];

    state_t      state_reg;
    logic [9:0]  len_reg;
    logic [9:0]  byte_idx_reg;
    logic [1:0]  wait_cnt_reg;
    logic [15:0] div_reg;
    logic        fc_en_reg;
    logic        need_low_reg;
    logic        vend_prev_reg;

    logic        vend_edge;
    logic [9:0]  len_clamped;
    logic [9:0]  idx_next;
    logic        ser_load;
    logic        ser_start;
    logic        ser_bit_end;
    logic        ser_last_bit;
    logic        ser_done;

    assign vend_edge   = vend_s && !vend_prev_reg;
    assign len_clamped = (buf_out_len > MAX_LEN) ? MAX_LEN : buf_out_len;
    assign idx_next    = byte_idx_reg + 10'd1;
    assign ser_load    = (state_reg == ST_LOAD);
    assign ser_start   = (state_reg == ST_CTS) && (!fc_en_reg || cts_s);

    always_ff @(posedge clk) begin
        if (!rst_n_reg) begin
            state_reg     <= ST_RST;
            len_reg       <= 10'd0;
            byte_idx_reg  <= 10'd0;
            wait_cnt_reg  <= 2'd0;
            div_reg       <= DIV_DEFAULT;
            fc_en_reg     <= 1'b0;
            need_low_reg  <= 1'b0;
            vend_prev_reg <= 1'b0;
            buf_out_addr  <= 9'd0;
            buf_out_arm   <= 1'b0;
            tx_busy       <= 1'b0;
        end else begin
            vend_prev_reg <= vend_s;
            if (vend_edge) begin
                if (vend_req_request == REQ_SET_DIV) begin
                    div_reg <= clamp_div(vend_req_val);
                end else if (vend_req_request == REQ_SET_FC) begin
                    fc_en_reg <= vend_req_val[0];
                end
            end

            // a packet is accepted only once hasdata has dropped since its predecessor was armed
            if (!hasdata_s) begin
                need_low_reg <= 1'b0;
            end

            case (state_reg)
                ST_RST: state_reg <= ST_IDLE;
                ST_IDLE: begin
                    if (hasdata_s && !need_low_reg) begin
                        len_reg      <= len_clamped;
                        byte_idx_reg <= 10'd0;
                        buf_out_addr <= 9'd0;
                        wait_cnt_reg <= 2'd0;
                        tx_busy      <= 1'b1;
                        if (len_clamped == 10'd0) begin
                            state_reg   <= ST_ARM;
                            buf_out_arm <= 1'b1;
                        end else begin
                            state_reg <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    buf_out_addr <= byte_idx_reg[8:0];
                    if (wait_cnt_reg == 2'(BUF_RD_LAT)) begin
                        state_reg <= ST_LOAD;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 2'd1;
                    end
                end
                ST_LOAD: state_reg <= ST_CTS;
                ST_CTS: begin
                    if (ser_start) begin
                        state_reg <= ST_START;
                    end
                end
                ST_START: begin
                    if (ser_bit_end) begin
                        state_reg <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (ser_bit_end && ser_last_bit) begin
                        state_reg <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (ser_done) begin
                        byte_idx_reg <= idx_next;
                        wait_cnt_reg <= 2'd0;
                        if (idx_next == len_reg) begin
                            state_reg   <= ST_ARM;
                            buf_out_arm <= 1'b1;
                        end else begin
                            state_reg    <= ST_FETCH;
                            buf_out_addr <= idx_next[8:0];
                        end
                    end
                end
                ST_ARM: begin
                    if (arm_ack_s) begin
                        buf_out_arm  <= 1'b0;
                        tx_busy      <= 1'b0;
                        need_low_reg <= 1'b1;
                        state_reg    <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_RST;
            endcase
        end
    end

    uart_tx_ser u_ser (
        .clk      (clk),
        .rst_n    (rst_n_reg),
        .load     (ser_load),
        .tx_byte  (buf_out_q),
        .bit_div  (div_reg),
        .start    (ser_start),
        .bit_end  (ser_bit_end),
        .last_bit (ser_last_bit),
        .done     (ser_done),
        .txd      (rs232_txd)
    );

endmodule
